// File: rtl/imem_arbiter.sv
// Single-port access controller for the instruction memory: round-robin between
// core fetch and a loader/debug port, with a timeout-bounded loader lock.
module imem_arbiter #(
  parameter int Addr_bits = 32,
  parameter int Word_size = 32,
  parameter int MAX_LOCK  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req,
  input  logic [Addr_bits-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [Word_size-1:0] f_rdata,
  input  logic                 l_req,
  input  logic                 l_we,
  input  logic                 l_lock,
  input  logic [Addr_bits-1:0] l_addr,
  input  logic [Word_size-1:0] l_wdata,
  output logic                 l_gnt,
  output logic                 l_rvalid,
  output logic [Word_size-1:0] l_rdata,
  output logic [Addr_bits-1:0] mem_addr,
  output logic                 mem_we,
  output logic [Word_size-1:0] mem_wdata,
  input  logic [Word_size-1:0] mem_rdata,
  output logic                 dbg_state_o
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  // Handshake: a requester raises req with addr/we/wdata and holds them stable
  // until it sees gnt=1 in the same cycle; the access completes on that edge.
  // Reads return data with rvalid exactly one cycle after the grant.
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic           f_rvalid_q, f_rvalid_d;
  logic           l_rvalid_q, l_rvalid_d;
  logic [Word_size-1:0] f_rdata_q, f_rdata_d;
  logic [Word_size-1:0] l_rdata_q, l_rdata_d;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    case (state_q)
      ARB: begin
        // last_q=1 means the loader won most recently, so fetch wins a tie.
        if (f_req && (!l_req || last_q)) f_gnt = 1'b1;
        else if (l_req)                  l_gnt = 1'b1;
        if (f_gnt) last_d = 1'b0;
        if (l_gnt) begin
          last_d = 1'b1;
          if (l_lock) begin
            state_d    = LOCK;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCK: begin
        l_gnt      = l_req;
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (l_gnt) last_d = 1'b1;
        // Both voluntary exits reduce to l_lock dropping; the timeout wins over both.
        if (lock_cnt_q == CW'(MAX_LOCK)) begin
          state_d    = ARB;
          last_d     = 1'b1;
          lock_cnt_d = '0;
        end else if (!l_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign mem_addr  = l_gnt ? l_addr : f_addr;
  assign mem_we    = l_gnt & l_we;
  assign mem_wdata = l_wdata;

  always_comb begin
    f_rvalid_d = f_gnt;
    l_rvalid_d = l_gnt & ~l_we;
    f_rdata_d  = f_gnt ? mem_rdata : f_rdata_q;
    l_rdata_d  = l_rvalid_d ? mem_rdata : l_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign f_rvalid    = f_rvalid_q;
  assign l_rvalid    = l_rvalid_q;
  assign f_rdata     = f_rdata_q;
  assign l_rdata     = l_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port access controller for the instruction memory (`I_memory`, word-addressed, combinational read). It shares the memory between the core fetch port and a program-loader/debug port that can both read and write. Arbitration is round-robin, and the loader can lock the memory for back-to-back load bursts, bounded by a timeout. Read data is registered and returned one cycle after grant.

## Interface
- `Addr_bits`, 32, memory word-address width
- `Word_size`, 32, memory data width
- `MAX_LOCK`, 16, maximum consecutive loader-locked cycles before a forced release (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `f_req`  in  1  fetch read request
- `f_addr`  in  Addr_bits  fetch word address
- `f_gnt`  out  1  fetch granted this cycle (combinational)
- `f_rvalid`  out  1  fetch read data valid (registered)
- `f_rdata`  out  Word_size  fetch read data (registered)
- `l_req`  in  1  loader request
- `l_we`  in  1  loader write (1) / read (0)
- `l_lock`  in  1  loader requests exclusive burst
- `l_addr`  in  Addr_bits  loader word address
- `l_wdata`  in  Word_size  loader write data
- `l_gnt`  out  1  loader granted this cycle (combinational)
- `l_rvalid`  out  1  loader read data valid (registered, reads only)
- `l_rdata`  out  Word_size  loader read data (registered)
- `mem_addr`  out  Addr_bits  to memory `addr`
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  Word_size  memory write data
- `mem_rdata`  in  Word_size  from memory `instr`

## Operation
- Two states: ARB and LOCK. Internal `last` bit records the last winner (0 = fetch, 1 = loader). Internal `lock_cnt` is a counter `$clog2(MAX_LOCK+1)` bits wide.
- ARB state:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port that is not `last` wins.
  - `last` updates on every grant.
- ARB to LOCK: on a loader grant with `l_lock`=1. `lock_cnt` loads 1.
- LOCK state:
  - `f_gnt`=0 always. `l_gnt`=`l_req`.
  - `lock_cnt` increments every cycle in LOCK.
- LOCK to ARB, on whichever occurs first:
  - a loader grant with `l_lock`=0 (that access still completes);
  - a cycle with `l_req`=0 and `l_lock`=0;
  - `lock_cnt`==`MAX_LOCK`. This is a forced release: `last` is set to 1, so a pending fetch wins the next contention.
- Memory drive (combinational):
  - `mem_addr` = `l_addr` when `l_gnt`=1, else `f_addr`.
  - `mem_we` = `l_gnt & l_we`.
  - `mem_wdata` = `l_wdata`.
- Read return:
  - On a read grant, `mem_rdata` is captured into the winner's `rdata` register at the clock edge, and that port's `rvalid` is set for exactly one cycle.
  - Loader writes produce no `rvalid`.
  - Each `rdata` register holds its value until the next read grant to the same port.
- `f_gnt` and `l_gnt` are never both 1.

## Timing
- Grant is combinational from the requests and the current state, in the same cycle. Requesters hold `req`, `addr`, `we`, `wdata` stable until they see `gnt`=1.
- Read latency: data is valid in the cycle after the grant (`rvalid` cycle).
- Throughput: one access per cycle total. Under continuous contention, fetch and loader alternate.
- Reset (`rst_n`=0, asynchronous) forces:
  - state=ARB, `last`=1, `lock_cnt`=0;
  - `f_rvalid`=`l_rvalid`=0, `f_rdata`=`l_rdata`=0.
- Reset mid-burst or mid-read drops the lock and any pending `rvalid`. No retry is performed.
- While `rst_n`=0, `mem_we` is still combinational. The integration ties `l_req` low during reset.
- A request deasserted before grant is simply not serviced. No state is kept for it.

## Test plan
- Reset, then fetch only, `f_addr`=0..24 over consecutive cycles -> `f_gnt`=1 every cycle; `f_rvalid`=1 one cycle later with `f_rdata`=mem[addr]; `l_rvalid`=0 throughout.
- Both requesting from reset, loader read at 5, fetch at 3 -> fetch granted first (`last`=1 after reset), loader granted next cycle; alternation continues while both are held.
- Loader writes 0xDEADBEEF to 7, then fetch reads 7 -> `mem_we`=1 for exactly one cycle; `f_rdata`=0xDEADBEEF one cycle after the fetch grant.
- Loader burst with `l_lock`=1 for 4 writes, `f_req`=1 throughout, `MAX_LOCK`=16 -> `f_gnt`=0 for 4 cycles. Fetch is granted the cycle after the loader sends its final write with `l_lock`=0.
- Loader holds `l_lock`=1 indefinitely with `MAX_LOCK`=4 and `f_req`=1 -> after 4 locked cycles the lock is forced to release and fetch wins the next cycle.
- Assert `rst_n`=0 in the cycle after a loader read grant -> `l_rvalid` stays 0, state returns to ARB, and the first post-reset contention goes to fetch.
